avalon_mm_fanout_bridge: RTL
============================

Name: avalon_mm_fanout_bridge

Overview:
Parametrised Avalon-MM bridge from one upstream simple master to NUM_CH downstream exported Avalon-MM slave channels. Upper address bits select the channel and lower bits form the channel offset. Adds per-transaction timeout, decode-error response and a sticky error status. Sits between the simple master and the exported slave windows in the system.

Parameters:
ADDR_W, 8, upstream address width.
DATA_W, 32, data width, all ports.
NUM_CH, 4, downstream channel count (1..2^(ADDR_W-CH_ADDR_W)).
CH_ADDR_W, 2, per-channel address width; must be < ADDR_W.
TIMEOUT, 256, max cycles in ISSUE before abort (>=2).
ERR_DATA, 32'hDEAD_BEEF, readdata returned on error (DATA_W-truncated).

Ports:
clk_clk  in  1  sole clock
reset_reset  in  1  synchronous, active-high reset
s_address  in  ADDR_W  upstream address
s_read  in  1  upstream read request
s_write  in  1  upstream write request
s_writedata  in  DATA_W  upstream write data
s_readdata  out  DATA_W  upstream read data, valid when s_waitrequest=0
s_waitrequest  out  1  upstream stall
m_address  out  NUM_CH*CH_ADDR_W  per-channel offset, packed, ch0 at LSBs
m_read  out  NUM_CH  per-channel read strobe
m_write  out  NUM_CH  per-channel write strobe
m_writedata  out  DATA_W  write data shared by all channels
m_readdata  in  NUM_CH*DATA_W  per-channel read data, packed
m_waitrequest  in  NUM_CH  per-channel stall
err_flag  out  1  sticky error (timeout or decode)
err_code  out  2  last error: 01 timeout, 10 decode
err_ch  out  clog2(NUM_CH) or 1  channel index of last timeout
err_clear  in  1  clears err_flag/err_code

Behaviour:
- Clock clk_clk; reset_reset synchronous, active-high. Reset: FSM=IDLE, s_waitrequest=1, s_readdata=0, m_read=m_write=0, m_address=0, m_writedata=0, err_flag=0, err_code=0, err_ch=0, timeout counter=0.
- FSM states: IDLE, ISSUE, DONE. All outputs registered.
- IDLE: s_waitrequest=1. On s_read|s_write, latch cmd, ch=s_address[ADDR_W-1:CH_ADDR_W], off=s_address[CH_ADDR_W-1:0], wdata. If s_read and s_write both high: read only, write suppressed. If ch>=NUM_CH: rdata<=ERR_DATA, err_flag<=1, err_code<=10, go to DONE without touching any channel. Otherwise assert m_read[ch] or m_write[ch], drive m_address slice ch=off and m_writedata=wdata, clear counter, go to ISSUE.
- ISSUE: strobes held stable. On m_waitrequest[ch]=0: capture m_readdata[ch] (writes capture nothing) and drop strobes the next edge; go to DONE. Otherwise counter++. If counter==TIMEOUT-1 with waitrequest still high: drop strobes, rdata<=ERR_DATA (reads), err_flag<=1, err_code<=01, err_ch<=ch; go to DONE.
- DONE: s_waitrequest=0 for exactly one cycle, s_readdata=rdata (writes: previous value, don't-care); go to IDLE. Upstream must hold its command through DONE.
- Latency, zero-wait channel: command seen in IDLE at cycle N, s_waitrequest low at cycle N+2; each downstream wait state adds 1. Decode error: low at N+1. Timeout: low at N+TIMEOUT+1.
- Non-selected channels: strobes stay 0 throughout.
- err_clear: clears err_flag/err_code/err_ch next edge. A new error in the same cycle wins (set over clear).
- Reset in ISSUE: all strobes deasserted next edge and the downstream transfer is abandoned. No response goes upstream.
- One outstanding transaction; no pipelining and no burst support.

Decomposition:
- Package avalon_bridge_pkg: state enum (IDLE, ISSUE, DONE), err_code constants (ERR_NONE=00, ERR_TIMEOUT=01, ERR_DECODE=10), default ERR_DATA.
- Sub-module bridge_timeout_ctr: clear/enable counter with terminal-count output at TIMEOUT-1. Instantiated once.

Test Plan:
- Write, NUM_CH=4: addr 0x05, wdata 0x1234_5678, ch1 zero-wait -> m_write[1]=1 one cycle, m_address[3:2]=01, m_writedata=0x1234_5678, s_waitrequest low 2 cycles after request, other strobes 0.
- Read: addr 0x0B, ch2 waitrequest high 3 cycles, readdata 0xCAFE_0002 -> m_read[2] held 4 cycles, s_readdata=0xCAFE_0002 with s_waitrequest low at N+5.
- Timeout, TIMEOUT=8: read addr 0x0C, ch3 waitrequest stuck high -> strobe dropped after 8 cycles, s_readdata=0xDEAD_BEEF, err_flag=1, err_code=01, err_ch=3.
- Decode, NUM_CH=3: read addr 0x0D (ch3) -> no m_read asserted, s_readdata=0xDEAD_BEEF at N+1, err_code=10.
- Reset during ISSUE (ch0 stalled) -> m_read=0 next edge, s_waitrequest=1, err_flag=0. Next write to ch0 completes normally.
- err_clear asserted in the same cycle as a new timeout -> err_flag remains 1. err_clear alone next cycle -> err_flag=0, err_code=00.

Source files
------------

// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Avalon-MM fan-out bridge.
package avalon_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  ERR_NONE         = 2'b00;
  localparam logic [1:0]  ERR_TIMEOUT      = 2'b01;
  localparam logic [1:0]  ERR_DECODE       = 2'b10;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Per-transaction wait counter; tc flags the last permitted stall cycle.
module bridge_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/avalon_mm_fanout_bridge.sv
// One upstream Avalon-MM master fanned out to NUM_CH slave windows, with
// timeout, decode-error response and sticky error status.
//
//   state | meaning
//   IDLE  | waiting for upstream read/write; decode channel
//   ISSUE | strobe held on selected channel until it stops stalling
//   DONE  | one-cycle upstream response (s_waitrequest low)
module avalon_mm_fanout_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter int          NUM_CH    = 4,
  parameter int          CH_ADDR_W = 2,
  parameter int          TIMEOUT   = 256,
  parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA,
  localparam int         CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [ADDR_W-1:0]           s_address,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [DATA_W-1:0]           s_writedata,
  output logic [DATA_W-1:0]           s_readdata,
  output logic                        s_waitrequest,
  output logic [NUM_CH*CH_ADDR_W-1:0] m_address,
  output logic [NUM_CH-1:0]           m_read,
  output logic [NUM_CH-1:0]           m_write,
  output logic [DATA_W-1:0]           m_writedata,
  input  logic [NUM_CH*DATA_W-1:0]    m_readdata,
  input  logic [NUM_CH-1:0]           m_waitrequest,
  output logic                        err_flag,
  output logic [1:0]                  err_code,
  output logic [CH_IDX_W-1:0]         err_ch,
  input  logic                        err_clear
);

  localparam int                SEL_W    = ADDR_W - CH_ADDR_W;
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  state_t                      state_q, state_d;
  logic                        rd_q, rd_d;
  logic [SEL_W-1:0]            ch_q, ch_d;
  logic [SEL_W-1:0]            s_sel;
  logic [DATA_W-1:0]           s_readdata_d, m_writedata_d, sel_rdata;
  logic                        s_waitrequest_d, sel_wait;
  logic [NUM_CH*CH_ADDR_W-1:0] m_address_d;
  logic [NUM_CH-1:0]           m_read_d, m_write_d;
  logic                        err_flag_d;
  logic [1:0]                  err_code_d;
  logic [CH_IDX_W-1:0]         err_ch_d;
  logic                        timeout_hit, decode_hit;
  logic                        cnt_clr, cnt_en, cnt_tc;

  assign s_sel = s_address[ADDR_W-1:CH_ADDR_W];

  bridge_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk (clk_clk),
    .rst (reset_reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    sel_wait  = 1'b1;
    sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_q) == i) begin
        sel_wait  = m_waitrequest[i];
        sel_rdata = m_readdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    ch_d            = ch_q;
    s_waitrequest_d = 1'b1;
    s_readdata_d    = s_readdata;
    m_read_d        = m_read;
    m_write_d       = m_write;
    m_address_d     = m_address;
    m_writedata_d   = m_writedata;
    timeout_hit     = 1'b0;
    decode_hit      = 1'b0;
    cnt_clr         = 1'b1;
    cnt_en          = 1'b0;

    case (state_q)
      IDLE: begin
        m_read_d  = '0;
        m_write_d = '0;
        if (s_read || s_write) begin
          rd_d = s_read;
          ch_d = s_sel;
          if (int'(s_sel) >= NUM_CH) begin
            s_readdata_d    = ERR_WORD;
            decode_hit      = 1'b1;
            s_waitrequest_d = 1'b0;
            state_d         = DONE;
          end else begin
            // Read wins when both strobes arrive together.
            m_address_d   = '0;
            m_writedata_d = s_writedata;
            for (int i = 0; i < NUM_CH; i++) begin
              if (int'(s_sel) == i) begin
                m_address_d[i*CH_ADDR_W +: CH_ADDR_W] = s_address[CH_ADDR_W-1:0];
                m_read_d[i]  = s_read;
                m_write_d[i] = !s_read;
              end
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_clr = 1'b0;
        if (!sel_wait) begin
          if (rd_q) s_readdata_d = sel_rdata;
          m_read_d        = '0;
          m_write_d       = '0;
          s_waitrequest_d = 1'b0;
          state_d         = DONE;
        end else if (cnt_tc) begin
          if (rd_q) s_readdata_d = ERR_WORD;
          m_read_d        = '0;
          m_write_d       = '0;
          timeout_hit     = 1'b1;
          s_waitrequest_d = 1'b0;
          state_d         = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh error in the same cycle as err_clear takes priority.
  always_comb begin
    err_flag_d = err_flag;
    err_code_d = err_code;
    err_ch_d   = err_ch;
    if (err_clear) begin
      err_flag_d = 1'b0;
      err_code_d = ERR_NONE;
      err_ch_d   = '0;
    end
    if (timeout_hit) begin
      err_flag_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
      err_ch_d   = ch_q[CH_IDX_W-1:0];
    end
    if (decode_hit) begin
      err_flag_d = 1'b1;
      err_code_d = ERR_DECODE;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      rd_q          <= 1'b0;
      ch_q          <= '0;
      s_waitrequest <= 1'b1;
      s_readdata    <= '0;
      m_read        <= '0;
      m_write       <= '0;
      m_address     <= '0;
      m_writedata   <= '0;
      err_flag      <= 1'b0;
      err_code      <= ERR_NONE;
      err_ch        <= '0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      ch_q          <= ch_d;
      s_waitrequest <= s_waitrequest_d;
      s_readdata    <= s_readdata_d;
      m_read        <= m_read_d;
      m_write       <= m_write_d;
      m_address     <= m_address_d;
      m_writedata   <= m_writedata_d;
      err_flag      <= err_flag_d;
      err_code      <= err_code_d;
      err_ch        <= err_ch_d;
    end
  end

endmodule
